mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single processor-memory port among three requesters: store commit (ROB head store), load issue (load buffer) and instruction fetch. It replaces the blanket fetch stall on memory activity with per-cycle arbitration, tracks outstanding load/fetch transactions by memory tag, and routes returned data to its owner. It sits between the ROB/load buffer/IF stage and the memory model.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 8: maximum in-flight load plus fetch transactions.
- `STARVE_LIMIT`, default 8: consecutive denied fetch cycles before fetch is promoted above load.
- `LB_IDX_W`, default 3: width of the load buffer entry index.

Ports:
- `clock` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `st_req` in 1; `st_addr` in 32; `st_data` in 64; `st_grant` out 1: store commit request.
- `ld_req` in 1; `ld_addr` in 32; `ld_idx` in LB_IDX_W; `ld_grant` out 1: load request.
- `ld_resp_valid` out 1; `ld_resp_idx` out LB_IDX_W; `ld_resp_data` out 64: load data return.
- `if_req` in 1; `if_addr` in 32; `if_grant` out 1: fetch request.
- `if_resp_valid` out 1; `if_resp_data` out 64: fetch data return.
- `proc2mem_command` out 2; `proc2mem_addr` out 32; `proc2mem_data` out 64: memory request.
- `mem2proc_response` in 4: accept tag, 0 means rejected.
- `mem2proc_data` in 64; `mem2proc_tag` in 4: data return, tag 0 means none.
- `outstanding_full` out 1: in-flight count equals MAX_OUTSTANDING.
- `err_unknown_tag` out 1: sticky; a nonzero return tag was not present in the table.

## Operation
- **Priority (default):** store > load > fetch.
- **Promoted priority:** when the starvation counter equals STARVE_LIMIT, the order is store > fetch > load.
- **Outstanding limit:** when `outstanding_full` is high, load and fetch are ineligible. Stores remain eligible; they are not tracked.
- **Command drive:** the winner drives `proc2mem_*` with command BUS_STORE or BUS_LOAD. With no winner, the command is BUS_NONE and addr/data are 0.
- **Grant:** asserted only for the winner, and only when `mem2proc_response != 0`. A rejected request gets no grant; the requester holds its request.
- **Allocation:** a granted load or fetch writes `{owner, ld_idx}` into the tag table at index `mem2proc_response`, sets that entry valid and increments the count.
- **Return:** `mem2proc_tag != 0` and the entry is valid:
  - owner LOAD: assert `ld_resp_valid` with `ld_resp_idx` from the entry and `ld_resp_data = mem2proc_data`;
  - owner FETCH: assert `if_resp_valid` with the data;
  - the entry is cleared and the count decremented at the next edge.
- **Unknown tag:** a return with an invalid entry is otherwise ignored and sets `err_unknown_tag`.
- **Return and allocation in the same cycle:** the count is unchanged. If both use the same tag, the clear is applied first, then the allocation, so the entry ends valid with the new owner.
- **Starvation counter:**
  - increments when `if_req & ~if_grant`, saturating at STARVE_LIMIT;
  - clears on `if_grant` or `~if_req`.

## Timing
- Arbitration, grant and `proc2mem_*` are combinational from the same-cycle requests and `mem2proc_response`. The block adds zero cycles of latency.
- Response routing is combinational from `mem2proc_tag` and the registered table. The table, count and starvation counter update at `posedge clock`.
- **Reset values:**
  - table all invalid, count 0, starvation counter 0, `err_unknown_tag` 0;
  - with requests low, all grants, resp_valids and `outstanding_full` are 0, and `proc2mem_command` is BUS_NONE.
- **Reset mid-operation:** all in-flight tags are dropped. Later returns of those tags set `err_unknown_tag`, so benches must reset the memory model together with this block.
- **Boundary on the limit:** with count = MAX_OUTSTANDING - 1, one allocation raises `outstanding_full` next cycle. A same-cycle return plus allocation keeps it low.

## Structure
- Shared package (`sys_defs`):
  - `BUS_NONE`/`BUS_LOAD`/`BUS_STORE` command encoding;
  - `mem_owner_e` (OWN_LOAD, OWN_FETCH);
  - `mem_tag_entry_t` struct `{valid, owner, lb_idx}`.
- Sub-module `mem_tag_table`: 16-entry register array with write port (alloc tag, entry), clear port (return tag) and combinational read by return tag. It implements clear-before-alloc ordering.
- Arbitration, counters and the error flag live in the top module.

## Test plan
- **Store wins a three-way race:** `st_req`, `ld_req` and `if_req` high, response=3 → `st_grant` only; BUS_STORE with `st_addr`/`st_data`; count stays 0.
- **Load round trip:** `ld_req` with idx=5, response=2 → `ld_grant`, entry 2 = LOAD/5. Later tag=2, data=0xDEAD → `ld_resp_valid`, idx 5, data 0xDEAD; count returns to 0.
- **Fetch promotion:** `ld_req` and `if_req` held high, all accepted → fetch is denied 8 cycles. The 9th cycle grants fetch; the next cycle grants load again.
- **Outstanding limit:** 8 loads accepted with no returns → `outstanding_full`=1; further `ld_req`/`if_req` give BUS_NONE; `st_req` is still granted. One return → `outstanding_full`=0 next cycle.
- **Same-tag clear and allocation:** tag 4 returns in the same cycle a new fetch is accepted with response 4 → load data routed; entry 4 = FETCH valid; count unchanged.
- **Unknown tag:** return tag 7 with the table empty → no resp_valid; `err_unknown_tag`=1 and it stays high until reset.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared processor/memory bus encodings and the tag-table entry layout.
package sys_defs;

   localparam int unsigned TAG_W        = 4;
   localparam int unsigned NUM_TAGS     = 1 << TAG_W;
   localparam int unsigned LB_IDX_MAX_W = 8;
   localparam int unsigned ADDR_W       = 32;
   localparam int unsigned DATA_W       = 64;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } bus_command_e;

   typedef enum logic {
      OWN_LOAD  = 1'b0,
      OWN_FETCH = 1'b1
   } mem_owner_e;

   // lb_idx is sized for the widest load buffer; narrower users zero-extend
   typedef struct packed {
      logic                    valid;
      mem_owner_e              owner;
      logic [LB_IDX_MAX_W-1:0] lb_idx;
   } mem_tag_entry_t;

endpackage

// File: rtl/mem_port_arbiter_tag_table.sv
// Per-memory-tag ownership record for in-flight loads and fetches.
module mem_tag_table
   import sys_defs::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 alloc_en,
   input  logic [TAG_W-1:0]     alloc_tag,
   input  mem_tag_entry_t       alloc_entry,
   input  logic                 clr_en,
   input  logic [TAG_W-1:0]     clr_tag,
   input  logic [TAG_W-1:0]     rd_tag,
   output mem_tag_entry_t       rd_entry
);

   mem_tag_entry_t tags_q [NUM_TAGS];
   mem_tag_entry_t tags_d [NUM_TAGS];

   // Clear first so a same-tag reallocation leaves the new owner valid
   always_comb begin
      tags_d = tags_q;
      if (clr_en) begin
         tags_d[clr_tag].valid = 1'b0;
      end
      if (alloc_en) begin
         tags_d[alloc_tag] = alloc_entry;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_TAGS); i++) begin
            tags_q[i] <= '0;
         end
      end else begin
         tags_q <= tags_d;
      end
   end

   assign rd_entry = tags_q[rd_tag];

endmodule

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbitration of the memory port between store commit, load issue
// and fetch, with tag tracking and data return routing.
module mem_port_arbiter
   import sys_defs::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 8,
   parameter int unsigned STARVE_LIMIT    = 8,
   parameter int unsigned LB_IDX_W        = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                st_req,
   input  logic [ADDR_W-1:0]   st_addr,
   input  logic [DATA_W-1:0]   st_data,
   output logic                st_grant,
   input  logic                ld_req,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [LB_IDX_W-1:0] ld_idx,
   output logic                ld_grant,
   output logic                ld_resp_valid,
   output logic [LB_IDX_W-1:0] ld_resp_idx,
   output logic [DATA_W-1:0]   ld_resp_data,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_grant,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_resp_data,
   output logic [1:0]          proc2mem_command,
   output logic [ADDR_W-1:0]   proc2mem_addr,
   output logic [DATA_W-1:0]   proc2mem_data,
   input  logic [TAG_W-1:0]    mem2proc_response,
   input  logic [DATA_W-1:0]   mem2proc_data,
   input  logic [TAG_W-1:0]    mem2proc_tag,
   output logic                outstanding_full,
   output logic                err_unknown_tag
);

   localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {
      WIN_NONE,
      WIN_STORE,
      WIN_LOAD,
      WIN_FETCH
   } winner_e;

   logic [CNT_W-1:0]    count_q, count_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                err_q, err_d;

   winner_e        winner;
   logic           accepted, promote, ld_elig, if_elig;
   logic           alloc_en, ret_hit, ret_miss;
   mem_tag_entry_t alloc_entry, rd_entry;

   assign outstanding_full = (count_q == CNT_W'(MAX_OUTSTANDING));
   assign promote          = (starve_q == STARVE_W'(STARVE_LIMIT));
   assign accepted         = (mem2proc_response != '0);
   assign ld_elig          = ld_req && !outstanding_full;
   assign if_elig          = if_req && !outstanding_full;

   // Store always first; starvation swaps the load/fetch order
   always_comb begin
      winner = WIN_NONE;
      if (st_req) begin
         winner = WIN_STORE;
      end else if (promote && if_elig) begin
         winner = WIN_FETCH;
      end else if (ld_elig) begin
         winner = WIN_LOAD;
      end else if (if_elig) begin
         winner = WIN_FETCH;
      end
   end

   always_comb begin
      proc2mem_command = BUS_NONE;
      proc2mem_addr    = '0;
      proc2mem_data    = '0;
      st_grant         = 1'b0;
      ld_grant         = 1'b0;
      if_grant         = 1'b0;
      case (winner)
         WIN_STORE: begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = st_addr;
            proc2mem_data    = st_data;
            st_grant         = accepted;
         end
         WIN_LOAD: begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ld_addr;
            ld_grant         = accepted;
         end
         WIN_FETCH: begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = if_addr;
            if_grant         = accepted;
         end
         default: ;
      endcase
   end

   assign alloc_en           = ld_grant || if_grant;
   assign alloc_entry.valid  = 1'b1;
   assign alloc_entry.owner  = if_grant ? OWN_FETCH : OWN_LOAD;
   assign alloc_entry.lb_idx = ld_grant ? LB_IDX_MAX_W'(ld_idx) : '0;

   mem_tag_table u_tag_table (
      .clock       (clock),
      .reset       (reset),
      .alloc_en    (alloc_en),
      .alloc_tag   (mem2proc_response),
      .alloc_entry (alloc_entry),
      .clr_en      (ret_hit),
      .clr_tag     (mem2proc_tag),
      .rd_tag      (mem2proc_tag),
      .rd_entry    (rd_entry)
   );

   assign ret_hit  = (mem2proc_tag != '0) && rd_entry.valid;
   assign ret_miss = (mem2proc_tag != '0) && !rd_entry.valid;

   assign ld_resp_valid = ret_hit && (rd_entry.owner == OWN_LOAD);
   assign ld_resp_idx   = LB_IDX_W'(rd_entry.lb_idx);
   assign ld_resp_data  = mem2proc_data;
   assign if_resp_valid = ret_hit && (rd_entry.owner == OWN_FETCH);
   assign if_resp_data  = mem2proc_data;
   assign err_unknown_tag = err_q;

   always_comb begin
      count_d  = count_q;
      starve_d = starve_q;
      err_d    = err_q || ret_miss;
      if (alloc_en && !ret_hit) begin
         count_d = count_q + CNT_W'(1);
      end else if (!alloc_en && ret_hit) begin
         count_d = count_q - CNT_W'(1);
      end
      if (!if_req || if_grant) begin
         starve_d = '0;
      end else if (!promote) begin
         starve_d = starve_q + STARVE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q  <= '0;
         starve_q <= '0;
         err_q    <= 1'b0;
      end else begin
         count_q  <= count_d;
         starve_q <= starve_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus multi-cycle sequences.
module tb_mem_port_arbiter;

   localparam int W_NONE = 0;
   localparam int W_ST   = 1;
   localparam int W_LD   = 2;
   localparam int W_IF   = 3;
   localparam int MAX_OUT = 8;
   localparam logic [31:0] ST_A = 32'h0000_1000;
   localparam logic [63:0] ST_D = 64'hCAFE_F00D_1234_5678;
   localparam logic [31:0] IF_A = 32'h0000_3000;

   logic        clock, reset;
   logic        st_req, st_grant, ld_req, ld_grant, if_req, if_grant;
   logic [31:0] st_addr, ld_addr, if_addr, proc2mem_addr;
   logic [63:0] st_data, ld_resp_data, if_resp_data, proc2mem_data, mem2proc_data;
   logic [2:0]  ld_idx, ld_resp_idx;
   logic        ld_resp_valid, if_resp_valid, outstanding_full, err_unknown_tag;
   logic [1:0]  proc2mem_command;
   logic [3:0]  mem2proc_response, mem2proc_tag;

   mem_port_arbiter dut (
      .clock(clock), .reset(reset),
      .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_grant(st_grant),
      .ld_req(ld_req), .ld_addr(ld_addr), .ld_idx(ld_idx), .ld_grant(ld_grant),
      .ld_resp_valid(ld_resp_valid), .ld_resp_idx(ld_resp_idx), .ld_resp_data(ld_resp_data),
      .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant),
      .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
      .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
      .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag),
      .outstanding_full(outstanding_full), .err_unknown_tag(err_unknown_tag)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        st, ld, fe;
      logic [2:0]  idx;
      logic [3:0]  resp, tag;
      logic [63:0] data;
      int          win;
   } vec_t;

   typedef struct {
      logic [3:0] tag;
      bit         is_load;
      logic [2:0] idx;
   } sb_t;

   sb_t  sb[$];
   logic exp_err;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs[14];

   function automatic vec_t mk(logic st, logic ld, logic fe, logic [2:0] idx,
                               logic [3:0] resp, logic [3:0] tag, logic [63:0] data, int win);
      vec_t v;
      v.st = st; v.ld = ld; v.fe = fe; v.idx = idx;
      v.resp = resp; v.tag = tag; v.data = data; v.win = win;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      st_req = 1'b0; ld_req = 1'b0; if_req = 1'b0; ld_idx = '0;
      mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      sb.delete();
      exp_err = 1'b0;
   endtask

   // Drive one cycle, check combinational outputs mid-cycle, update the scoreboard
   task automatic step(input vec_t v);
      logic [1:0]  e_cmd;
      logic [31:0] e_addr;
      logic [63:0] e_data;
      logic        acc, e_ld, e_if;
      logic [2:0]  e_idx;
      int          hit;
      st_req = v.st; ld_req = v.ld; if_req = v.fe; ld_idx = v.idx;
      ld_addr = 32'h0000_2000 | 32'({v.idx, 3'b000});
      mem2proc_response = v.resp; mem2proc_tag = v.tag; mem2proc_data = v.data;
      @(negedge clock);
      acc = (v.resp != 4'd0);
      case (v.win)
         W_ST:    begin e_cmd = 2'd2; e_addr = ST_A;    e_data = ST_D; end
         W_LD:    begin e_cmd = 2'd1; e_addr = ld_addr; e_data = '0;   end
         W_IF:    begin e_cmd = 2'd1; e_addr = IF_A;    e_data = '0;   end
         default: begin e_cmd = 2'd0; e_addr = '0;      e_data = '0;   end
      endcase
      chk("st_grant", 64'(st_grant), 64'(v.win == W_ST && acc));
      chk("ld_grant", 64'(ld_grant), 64'(v.win == W_LD && acc));
      chk("if_grant", 64'(if_grant), 64'(v.win == W_IF && acc));
      chk("command",  64'(proc2mem_command), 64'(e_cmd));
      chk("addr",     64'(proc2mem_addr), 64'(e_addr));
      chk("data",     proc2mem_data, e_data);
      chk("outstanding_full", 64'(outstanding_full), 64'(sb.size() == MAX_OUT));
      chk("err_unknown_tag", 64'(err_unknown_tag), 64'(exp_err));
      hit = -1;
      if (v.tag != 4'd0) begin
         foreach (sb[i]) if (sb[i].tag == v.tag) hit = i;
      end
      e_ld = 1'b0; e_if = 1'b0; e_idx = '0;
      if (hit >= 0) begin
         e_ld  = sb[hit].is_load;
         e_if  = !sb[hit].is_load;
         e_idx = sb[hit].idx;
      end
      chk("ld_resp_valid", 64'(ld_resp_valid), 64'(e_ld));
      chk("if_resp_valid", 64'(if_resp_valid), 64'(e_if));
      if (e_ld) begin
         chk("ld_resp_idx", 64'(ld_resp_idx), 64'(e_idx));
         chk("ld_resp_data", ld_resp_data, v.data);
      end
      if (e_if) chk("if_resp_data", if_resp_data, v.data);
      if (hit >= 0) sb.delete(hit);
      else if (v.tag != 4'd0) exp_err = 1'b1;
      if (v.win == W_LD && acc) sb.push_back('{v.resp, 1'b1, v.idx});
      if (v.win == W_IF && acc) sb.push_back('{v.resp, 1'b0, 3'd0});
      @(posedge clock);
      #1;
   endtask

   initial begin
      int prev;
      st_addr = ST_A; st_data = ST_D; if_addr = IF_A; ld_addr = '0;
      exp_err = 1'b0;

      //             st    ld    if    idx   resp  tag   data                 winner
      vecs[0]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,               W_NONE);
      vecs[1]  = mk(1'b1, 1'b1, 1'b1, 3'd2, 4'd3, 4'd0, 64'h0,               W_ST);
      vecs[2]  = mk(1'b0, 1'b1, 1'b0, 3'd5, 4'd2, 4'd0, 64'h0,               W_LD);
      vecs[3]  = mk(1'b0, 1'b1, 1'b0, 3'd6, 4'd0, 4'd0, 64'h0,               W_LD);
      vecs[4]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd2, 64'hDEAD,            W_NONE);
      vecs[5]  = mk(1'b0, 1'b0, 1'b1, 3'd0, 4'd4, 4'd0, 64'h0,               W_IF);
      vecs[6]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd4, 64'hBEEF_0000_BEEF,  W_NONE);
      vecs[7]  = mk(1'b0, 1'b1, 1'b0, 3'd1, 4'd4, 4'd0, 64'h0,               W_LD);
      vecs[8]  = mk(1'b0, 1'b0, 1'b1, 3'd0, 4'd4, 4'd4, 64'h1111,            W_IF);
      vecs[9]  = mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd4, 64'h2222,            W_NONE);
      vecs[10] = mk(1'b0, 1'b1, 1'b1, 3'd3, 4'd0, 4'd0, 64'h0,               W_LD);
      vecs[11] = mk(1'b0, 1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 64'h0,               W_IF);
      vecs[12] = mk(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,               W_ST);
      vecs[13] = mk(1'b1, 1'b1, 1'b0, 3'd7, 4'd5, 4'd0, 64'h0,               W_ST);

      do_reset();
      foreach (vecs[i]) step(vecs[i]);

      // Fetch starved behind loads for STARVE_LIMIT cycles, then promoted once
      prev = 0;
      for (int c = 1; c <= 10; c++) begin
         step(mk(1'b0, 1'b1, 1'b1, 3'(c), 4'(c), 4'(prev), 64'h100 + 64'(c),
                 (c == 9) ? W_IF : W_LD));
         prev = c;
      end
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'(prev), 64'h5A5A, W_NONE));

      // Fill to the outstanding limit, then probe the boundary
      for (int t = 1; t <= MAX_OUT; t++) begin
         step(mk(1'b0, 1'b1, 1'b0, 3'(t), 4'(t), 4'd0, 64'h0, W_LD));
      end
      step(mk(1'b0, 1'b1, 1'b1, 3'd0, 4'd9, 4'd0, 64'h0, W_NONE));
      step(mk(1'b1, 1'b1, 1'b1, 3'd0, 4'd9, 4'd0, 64'h0, W_ST));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd1, 64'hA1, W_NONE));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));
      step(mk(1'b0, 1'b1, 1'b0, 3'd0, 4'd1, 4'd2, 64'hA2, W_LD));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));
      step(mk(1'b0, 1'b1, 1'b0, 3'd4, 4'd2, 4'd0, 64'h0,  W_LD));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));
      for (int n = 0; n < 16 && sb.size() > 0; n++) begin
         step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, sb[0].tag, 64'hD0 + 64'(n), W_NONE));
      end

      // Unknown tag is sticky until reset
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd7, 64'h77, W_NONE));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));

      // Reset drops an in-flight tag; its later return is unknown
      step(mk(1'b0, 1'b1, 1'b0, 3'd2, 4'd3, 4'd0, 64'h0, W_LD));
      do_reset();
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd3, 64'h33, W_NONE));
      step(mk(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 64'h0,  W_NONE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
